zigzag_reorder_pp: RTL

- Parametrised ping-pong reorder buffer between the quantiser (raster-order 8x8 coefficients) and the entropy coder (zig-zag order).
- Two 64-entry banks: one fills while the other drains. Valid/ready handshakes on both sides replace free-running enables.
- Each block can bypass the zig-zag reorder. Outputs carry component tags and block/MCU markers, with a configurable MCU layout.

---
 rtl/zigzag_reorder_pp_if.sv | 28 ++
 rtl/zigzag_reorder_pp.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/zigzag_reorder_pp_if.sv
// Handshake bundle between quantiser, zig-zag reorder buffer and entropy coder.
// The slave view belongs to the reorder buffer, the master view to its environment.
`timescale 1ns/1ps
interface zigzag_reorder_pp_if #(
   parameter int DATA_W = 12
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_bypass;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_comp;
   logic              out_sob;
   logic              out_eob;
   logic              out_eom;
   logic              out_ready;

   modport slave (
      input  in_valid, in_data, in_bypass, out_ready,
      output in_ready, out_valid, out_data, out_comp, out_sob, out_eob, out_eom
   );

   modport master (
      output in_valid, in_data, in_bypass, out_ready,
      input  in_ready, out_valid, out_data, out_comp, out_sob, out_eob, out_eom
   );
endinterface

// File: rtl/zigzag_reorder_pp.sv
// Ping-pong 8x8 coefficient buffer: raster-order writes into one bank while the
// other bank drains in zig-zag (or raster, when bypassed) order with MCU tagging.
`timescale 1ns/1ps
module zigzag_reorder_pp #(
   parameter int DATA_W = 12,
   parameter int Y_BLK  = 4,
   parameter int C_BLK  = 2
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   zigzag_reorder_pp_if.slave   bus
);

   localparam int NBLK = Y_BLK + 2 * C_BLK;
   localparam int BCW  = $clog2(NBLK + 1);
   localparam logic [BCW-1:0] Y_END    = BCW'(Y_BLK);
   localparam logic [BCW-1:0] CB_END   = BCW'(Y_BLK + C_BLK);
   localparam logic [BCW-1:0] LAST_BLK = BCW'(NBLK - 1);

   // Raster position of the k-th coefficient in zig-zag scan order.
   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic [DATA_W-1:0] mem_q [2][64];

   logic              wrBank_q, wrBank_d;
   logic [5:0]        wrIdx_q, wrIdx_d;
   logic              rdBank_q, rdBank_d;
   logic [5:0]        rdIdx_q, rdIdx_d;
   logic [1:0]        full_q, full_d;
   logic [1:0]        byp_q, byp_d;
   logic [BCW-1:0]    blkCnt_q, blkCnt_d;
   logic              outValid_q, outValid_d;
   logic [DATA_W-1:0] outData_q, outData_d;
   logic [1:0]        outComp_q, outComp_d;
   logic              outSob_q, outSob_d;
   logic              outEob_q, outEob_d;
   logic              outEom_q, outEom_d;

   logic              inReady;
   logic              accept;
   logic              load;
   logic [5:0]        rdAddr;

   assign inReady = !sys_rst && !full_q[wrBank_q];
   assign accept  = bus.in_valid && inReady;
   assign load    = full_q[rdBank_q] && (!outValid_q || bus.out_ready);
   assign rdAddr  = byp_q[rdBank_q] ? rdIdx_q : ZZ[rdIdx_q];

   always_comb begin
      wrBank_d   = wrBank_q;
      wrIdx_d    = wrIdx_q;
      rdBank_d   = rdBank_q;
      rdIdx_d    = rdIdx_q;
      full_d     = full_q;
      byp_d      = byp_q;
      blkCnt_d   = blkCnt_q;
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outComp_d  = outComp_q;
      outSob_d   = outSob_q;
      outEob_d   = outEob_q;
      outEom_d   = outEom_q;

      if (accept) begin
         wrIdx_d = wrIdx_q + 6'd1;
         if (wrIdx_q == 6'd0) begin
            byp_d[wrBank_q] = bus.in_bypass;
         end
         if (wrIdx_q == 6'd63) begin
            full_d[wrBank_q] = 1'b1;
            wrBank_d         = ~wrBank_q;
         end
      end

      // A write only targets a non-full bank and a read only a full one, so the
      // two flag updates above and below never touch the same bank.
      if (load) begin
         outData_d  = mem_q[rdBank_q][rdAddr];
         outValid_d = 1'b1;
         outSob_d   = (rdIdx_q == 6'd0);
         outEob_d   = (rdIdx_q == 6'd63);
         outComp_d  = (blkCnt_q < Y_END) ? 2'd1 : ((blkCnt_q < CB_END) ? 2'd2 : 2'd3);
         outEom_d   = (rdIdx_q == 6'd63) && (blkCnt_q == LAST_BLK);
         rdIdx_d    = rdIdx_q + 6'd1;
         if (rdIdx_q == 6'd63) begin
            full_d[rdBank_q] = 1'b0;
            rdBank_d         = ~rdBank_q;
            blkCnt_d         = (blkCnt_q == LAST_BLK) ? '0 : blkCnt_q + BCW'(1);
         end
      end else if (bus.out_ready) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wrBank_q   <= 1'b0;
         wrIdx_q    <= '0;
         rdBank_q   <= 1'b0;
         rdIdx_q    <= '0;
         full_q     <= '0;
         byp_q      <= '0;
         blkCnt_q   <= '0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outComp_q  <= '0;
         outSob_q   <= 1'b0;
         outEob_q   <= 1'b0;
         outEom_q   <= 1'b0;
      end else begin
         wrBank_q   <= wrBank_d;
         wrIdx_q    <= wrIdx_d;
         rdBank_q   <= rdBank_d;
         rdIdx_q    <= rdIdx_d;
         full_q     <= full_d;
         byp_q      <= byp_d;
         blkCnt_q   <= blkCnt_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outComp_q  <= outComp_d;
         outSob_q   <= outSob_d;
         outEob_q   <= outEob_d;
         outEom_q   <= outEom_d;
      end
   end

   // Bank storage is left out of reset: the cleared full flags keep stale data unreachable.
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         mem_q[wrBank_q][wrIdx_q] <= bus.in_data;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid_q;
   assign bus.out_data  = outData_q;
   assign bus.out_comp  = outComp_q;
   assign bus.out_sob   = outSob_q;
   assign bus.out_eob   = outEob_q;
   assign bus.out_eom   = outEom_q;

endmodule
